// File: rtl/pwm_ctrl_pkg.sv
// Purpose: shared types and constants for the PWM duty ramp controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// DUTY_STEPS is the full-scale duty code that the PWM generator also decodes
// (10 = 100%). ramp_state_t is the slew FSM state.
package pwm_ctrl_pkg;

    localparam int DUTY_STEPS = 10;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        RAMP_DOWN = 2'd2
    } ramp_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Purpose: synchronise and debounce one raw pushbutton, emit a 1-cycle press pulse on a debounced rising edge.
// Latency: press is high 2 + DEB_CYCLES cycles after the raw input settles high.
// Backpressure: none; the pulse is fire-and-forget, and held or released buttons give no pulse.
//
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous reset, active low
//   btn    in   raw asynchronous button level
//   press  out  one-cycle pulse per debounced press
module btn_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);

    localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level;
    logic             level_d;
    logic [CNT_W-1:0] cnt;

    // cnt is the length of the current run of synced samples that disagree
    // with the debounced level. Any sample that agrees breaks the run, so a
    // bouncing input never accumulates across bounces.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= btn;
            sync2   <= sync1;
            level_d <= level;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press = level & ~level_d;

endmodule

// File: rtl/pwm_duty_ramp_ctrl.sv
// Purpose: turn inc/dec buttons into a 0..STEPS duty target and slew the applied duty toward it on PWM period ends.
// Latency: target moves 3 + DEB_CYCLES cycles after a clean press; duty moves one step every RAMP_PERIODS period ends.
// Backpressure: none; presses are accepted immediately (saturating), and simultaneous inc+dec presses cancel.
//
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous reset, active low
//   inc_btn      in   raw increase button
//   dec_btn      in   raw decrease button
//   period_end   in   1-cycle pulse at PWM counter wrap
//   duty_step    out  applied duty code to the PWM generator
//   target_step  out  requested duty code
//   busy         out  applied duty still slewing toward target
//   at_max       out  target at full scale
//   at_min       out  target at zero
module pwm_duty_ramp_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES   = 4,
    parameter int STEPS        = DUTY_STEPS,
    parameter int STEP_W       = 4,
    parameter int RAMP_PERIODS = 2,
    parameter int INIT_STEP    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inc_btn,
    input  logic              dec_btn,
    input  logic              period_end,
    output logic [STEP_W-1:0] duty_step,
    output logic [STEP_W-1:0] target_step,
    output logic              busy,
    output logic              at_max,
    output logic              at_min
);

    localparam int PCNT_W = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(RAMP_PERIODS - 1);
    localparam logic [STEP_W-1:0] MAX_STEP  = STEP_W'(STEPS);
    localparam logic [STEP_W-1:0] INIT_VAL  = STEP_W'(INIT_STEP);

    logic              inc_press;
    logic              dec_press;
    logic [STEP_W-1:0] target_nxt;
    logic [STEP_W-1:0] duty_nxt;
    logic [PCNT_W-1:0] period_cnt;
    logic [PCNT_W-1:0] period_cnt_nxt;
    ramp_state_t       state;
    ramp_state_t       state_nxt;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (inc_btn),
        .press (inc_press)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_dec_deb (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (dec_btn),
        .press (dec_press)
    );

    // Saturation is checked before the add/subtract so the code never wraps.
    always_comb begin
        target_nxt = target_step;
        if (inc_press && !dec_press && (target_step != MAX_STEP)) begin
            target_nxt = target_step + STEP_W'(1);
        end else if (dec_press && !inc_press && (target_step != '0)) begin
            target_nxt = target_step - STEP_W'(1);
        end
    end

    // Slew FSM. Direction comes from the registered duty/target compare every
    // cycle rather than from the state, so a target that reverses mid-ramp
    // steers the very next step without restarting the period count. A press
    // landing in the same cycle as period_end only affects the next cycle,
    // because the decision reads target_step, not target_nxt.
    always_comb begin
        state_nxt      = state;
        period_cnt_nxt = period_cnt;
        duty_nxt       = duty_step;
        case (state)
            RAMP_UP, RAMP_DOWN: begin
                if (duty_step == target_step) begin
                    state_nxt      = IDLE;
                    period_cnt_nxt = '0;
                end else begin
                    state_nxt = (target_step > duty_step) ? RAMP_UP : RAMP_DOWN;
                    if (period_end) begin
                        if (period_cnt == PCNT_LAST) begin
                            period_cnt_nxt = '0;
                            if ((target_step > duty_step) && (duty_step != MAX_STEP)) begin
                                duty_nxt = duty_step + STEP_W'(1);
                            end else if ((target_step < duty_step) && (duty_step != '0)) begin
                                duty_nxt = duty_step - STEP_W'(1);
                            end
                        end else begin
                            period_cnt_nxt = period_cnt + PCNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                period_cnt_nxt = '0;
                if (target_step > duty_step) begin
                    state_nxt = RAMP_UP;
                end else if (target_step < duty_step) begin
                    state_nxt = RAMP_DOWN;
                end else begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            period_cnt  <= '0;
            duty_step   <= INIT_VAL;
            target_step <= INIT_VAL;
        end else begin
            state       <= state_nxt;
            period_cnt  <= period_cnt_nxt;
            duty_step   <= duty_nxt;
            target_step <= target_nxt;
        end
    end

    assign busy   = (duty_step != target_step);
    assign at_max = (target_step == MAX_STEP);
    assign at_min = (target_step == '0);

endmodule

// File: tb/tb_pwm_duty_ramp_ctrl.sv
// Purpose: self-checking bench for pwm_duty_ramp_ctrl against a cycle-level behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_pwm_duty_ramp_ctrl;

    localparam int DEB   = 4;
    localparam int RP    = 2;
    localparam int INIT  = 5;
    localparam int STEPS = 10;
    localparam int PER   = 20;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       inc_btn = 1'b0;
    logic       dec_btn = 1'b0;
    logic       period_end = 1'b0;
    logic [3:0] duty_step;
    logic [3:0] target_step;
    logic       busy;
    logic       at_max;
    logic       at_min;

    always #5 clk = ~clk;

    pwm_duty_ramp_ctrl #(
        .DEB_CYCLES   (DEB),
        .STEPS        (STEPS),
        .STEP_W       (4),
        .RAMP_PERIODS (RP),
        .INIT_STEP    (INIT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .inc_btn     (inc_btn),
        .dec_btn     (dec_btn),
        .period_end  (period_end),
        .duty_step   (duty_step),
        .target_step (target_step),
        .busy        (busy),
        .at_max      (at_max),
        .at_min      (at_min)
    );

    int total = 0;
    int bad   = 0;
    int pe_cnt = 0;

    // Behavioural model. h_* holds the raw button samples, newest in bit 0.
    // A button's debounced level follows once the DEB samples that have made
    // it through the two-stage synchroniser all agree on a new value.
    int         m_duty;
    int         m_tgt;
    int         m_periods;
    bit         m_slewing;
    logic [DEB:0] h_inc;
    logic [DEB:0] h_dec;
    bit         l_inc, l_dec;
    bit         p_inc, p_dec;
    bit         m_pe_edge;

    function automatic bit deb_level(input logic [DEB:0] h, input bit lvl);
        if (h[DEB:1] == '1) return 1'b1;
        if (h[DEB:1] == '0) return 1'b0;
        return lvl;
    endfunction

    task automatic model_edge();
        bit nl;
        int nt;
        m_pe_edge = period_end;
        if (!rst_n) begin
            m_duty    = INIT;
            m_tgt     = INIT;
            m_periods = 0;
            m_slewing = 0;
            h_inc = '0; h_dec = '0;
            l_inc = 0; l_dec = 0;
            p_inc = 0; p_dec = 0;
        end else begin
            nt = m_tgt;
            if (p_inc && !p_dec) nt = (m_tgt < STEPS) ? m_tgt + 1 : m_tgt;
            if (p_dec && !p_inc) nt = (m_tgt > 0) ? m_tgt - 1 : m_tgt;
            // Slewing starts the cycle after a mismatch is first visible and
            // counts period ends only while a mismatch remains.
            if (m_slewing && (m_duty != m_tgt)) begin
                if (period_end) begin
                    m_periods++;
                    if (m_periods == RP) begin
                        m_duty    = (m_tgt > m_duty) ? m_duty + 1 : m_duty - 1;
                        m_periods = 0;
                    end
                end
            end else begin
                m_periods = 0;
            end
            m_slewing = (m_duty != m_tgt);
            m_tgt = nt;
            nl = deb_level(h_inc, l_inc); p_inc = nl && !l_inc; l_inc = nl;
            nl = deb_level(h_dec, l_dec); p_dec = nl && !l_dec; l_dec = nl;
            h_inc = {h_inc[DEB-1:0], inc_btn};
            h_dec = {h_dec[DEB-1:0], dec_btn};
        end
    endtask

    // One clock: model sees the same inputs the DUT samples, then the period
    // pulse generator advances and outputs are settled for checking.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        pe_cnt     = (pe_cnt + 1) % PER;
        period_end = (pe_cnt == PER - 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            inc_btn = i[0];
            dec_btn = ~i[0];
            tick();
        end
        inc_btn = 1'b0;
        dec_btn = 1'b0;
        total++; if (duty_step !== 4'd5) begin bad++; $display("FAIL reset_duty got=%0d want=5", duty_step); end
        total++; if (target_step !== 4'd5) begin bad++; $display("FAIL reset_target got=%0d want=5", target_step); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
        total++; if (at_min !== 1'b0) begin bad++; $display("FAIL reset_at_min got=%0b want=0", at_min); end
        total++; if (at_max !== 1'b0) begin bad++; $display("FAIL reset_at_max got=%0b want=0", at_max); end
        rst_n = 1'b1;
    endtask

    task automatic test_single_press();
        do_reset();
        for (int i = 0; i < 2 * PER && pe_cnt != 0; i++) tick();
        inc_btn = 1'b1;
        for (int c = 1; c <= 120; c++) begin
            if (c == 101) inc_btn = 1'b0;
            tick();
            total++;
            if (duty_step !== 4'(m_duty) || target_step !== 4'(m_tgt) || busy !== (m_duty != m_tgt)) begin
                bad++;
                $display("FAIL single_model c=%0d duty=%0d/%0d tgt=%0d/%0d busy=%0b", c, duty_step, m_duty, target_step, m_tgt, busy);
            end
            if (c == 6) begin
                total++; if (target_step !== 4'd5) begin bad++; $display("FAIL single_early got=%0d want=5", target_step); end
            end
            if (c == 7) begin
                total++; if (target_step !== 4'd6 || busy !== 1'b1) begin bad++; $display("FAIL single_lat tgt=%0d busy=%0b want 6/1", target_step, busy); end
            end
            if (c == 39) begin
                total++; if (duty_step !== 4'd5) begin bad++; $display("FAIL single_pre_step got=%0d want=5", duty_step); end
            end
            if (c == 40) begin
                total++; if (duty_step !== 4'd6 || busy !== 1'b0) begin bad++; $display("FAIL single_step duty=%0d busy=%0b want 6/0", duty_step, busy); end
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int c = 0; c < 60; c++) begin
            inc_btn = (c < 40) ? c[1] : 1'b0;
            tick();
            total++;
            if (target_step !== 4'd5 || duty_step !== 4'd5 || target_step !== 4'(m_tgt)) begin
                bad++;
                $display("FAIL bounce c=%0d duty=%0d tgt=%0d want 5/5", c, duty_step, target_step);
            end
        end
    endtask

    task automatic test_saturate();
        logic [3:0] prev;
        do_reset();
        for (int c = 0; c < 7 * 20 + 400; c++) begin
            inc_btn = (c < 7 * 20) && ((c % 20) < 10);
            prev = duty_step;
            tick();
            total++;
            if (duty_step !== 4'(m_duty) || target_step !== 4'(m_tgt) || at_max !== (m_tgt == STEPS)) begin
                bad++;
                $display("FAIL sat_model c=%0d duty=%0d/%0d tgt=%0d/%0d", c, duty_step, m_duty, target_step, m_tgt);
            end
            if (duty_step !== prev) begin
                total++;
                if (!m_pe_edge || (int'(duty_step) - int'(prev)) != 1) begin
                    bad++;
                    $display("FAIL sat_step c=%0d from=%0d to=%0d pe=%0b", c, prev, duty_step, m_pe_edge);
                end
            end
        end
        total++; if (target_step !== 4'd10 || at_max !== 1'b1) begin bad++; $display("FAIL sat_target tgt=%0d at_max=%0b want 10/1", target_step, at_max); end
        total++; if (duty_step !== 4'd10 || busy !== 1'b0) begin bad++; $display("FAIL sat_duty duty=%0d busy=%0b want 10/0", duty_step, busy); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        inc_btn = 1'b1;
        dec_btn = 1'b1;
        for (int c = 0; c < 130; c++) begin
            if (c == 100) begin inc_btn = 1'b0; dec_btn = 1'b0; end
            tick();
            total++;
            if (target_step !== 4'd5 || duty_step !== 4'd5) begin
                bad++;
                $display("FAIL simult c=%0d duty=%0d tgt=%0d want 5/5", c, duty_step, target_step);
            end
        end
    endtask

    task automatic press(input bit up, input int n);
        for (int c = 0; c < 20 * n; c++) begin
            inc_btn = up && ((c % 20) < 10);
            dec_btn = !up && ((c % 20) < 10);
            tick();
            total++;
            if (duty_step !== 4'(m_duty) || target_step !== 4'(m_tgt) || busy !== (m_duty != m_tgt)) begin
                bad++;
                $display("FAIL press_model c=%0d duty=%0d/%0d tgt=%0d/%0d", c, duty_step, m_duty, target_step, m_tgt);
            end
        end
        inc_btn = 1'b0;
        dec_btn = 1'b0;
    endtask

    task automatic test_reversal();
        int c;
        do_reset();
        press(1'b1, 3);
        total++; if (target_step !== 4'd8) begin bad++; $display("FAIL rev_up_target got=%0d want=8", target_step); end
        c = 0;
        while (duty_step !== 4'd6 && c < 400) begin tick(); c++; end
        total++; if (duty_step !== 4'd6) begin bad++; $display("FAIL rev_reach6 timeout duty=%0d want=6", duty_step); end
        press(1'b0, 3);
        total++; if (target_step !== 4'd5) begin bad++; $display("FAIL rev_dn_target got=%0d want=5", target_step); end
        c = 0;
        while (busy !== 1'b0 && c < 400) begin
            tick(); c++;
            total++;
            if (duty_step !== 4'(m_duty) || target_step !== 4'(m_tgt)) begin
                bad++;
                $display("FAIL rev_model c=%0d duty=%0d/%0d tgt=%0d/%0d", c, duty_step, m_duty, target_step, m_tgt);
            end
        end
        total++; if (duty_step !== 4'd5 || busy !== 1'b0) begin bad++; $display("FAIL rev_settle duty=%0d busy=%0b want 5/0", duty_step, busy); end
        // Start a fresh ramp and abandon it with reset.
        press(1'b1, 2);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL rev_ramp busy=%0b want=1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 60; k++) begin
            tick();
            total++;
            if (duty_step !== 4'd5 || target_step !== 4'd5 || busy !== 1'b0) begin
                bad++;
                $display("FAIL rev_midreset k=%0d duty=%0d tgt=%0d busy=%0b want 5/5/0", k, duty_step, target_step, busy);
            end
        end
    endtask

    task automatic test_random();
        int hold;
        do_reset();
        for (int seg = 0; seg < 120; seg++) begin
            inc_btn = 1'($urandom_range(0, 1));
            dec_btn = 1'($urandom_range(0, 2) == 0);
            rst_n   = ($urandom_range(0, 39) != 0);
            hold    = $urandom_range(1, 25);
            for (int k = 0; k < hold; k++) begin
                if (k == 1) rst_n = 1'b1;
                tick();
                total++;
                if (duty_step !== 4'(m_duty) || target_step !== 4'(m_tgt) || busy !== (m_duty != m_tgt)
                    || at_max !== (m_tgt == STEPS) || at_min !== (m_tgt == 0)) begin
                    bad++;
                    $display("FAIL random seg=%0d k=%0d duty=%0d/%0d tgt=%0d/%0d", seg, k, duty_step, m_duty, target_step, m_tgt);
                end
            end
            rst_n = 1'b1;
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_bounce();
        test_saturate();
        test_simultaneous();
        test_reversal();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
